// File: rtl/atm_cash_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// atm_cash_dispense_ctrl
//
// Sequences the note-dispense mechanism of an ATM once a withdrawal has been
// authorised. On start it plans a 500/100 note mix against the cassette stock,
// checks that enough 100 notes remain, then drives the mechanism one note at a
// time over a note_req/note_ack handshake. All 500 notes go out before any
// 100 notes. It keeps both cassette counts and reports done or an error code.
//
// Optional feature: define DISPENSE_TIMEOUT_EN to abort a note that is not
// acknowledged within TIMEOUT_CYC request cycles (err_code 11). Without the
// macro the controller waits for note_ack indefinitely.
//
// Parameters
//   AMT_W        width of amount (units of 100)
//   CNT_W        width of each cassette note counter
//   TIMEOUT_CYC  request cycles allowed per note (timeout build only)
//
// Ports
//   clock      in   single clock, all state changes on its rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   1-cycle pulse, begin dispensing amount (IDLE only)
//   amount     in   withdrawal in units of 100, sampled with start
//   load_cass  in   1-cycle pulse, overwrite both counts (IDLE only, beats start)
//   load_c500  in   new 500-note count
//   load_c100  in   new 100-note count
//   note_req   out  request one note from the mechanism
//   note_sel   out  note type for note_req: 1 = 500, 0 = 100
//   note_ack   in   mechanism has dispensed the requested note
//   busy       out  high whenever not IDLE
//   done       out  1-cycle pulse, all planned notes dispensed
//   error      out  1-cycle pulse, request aborted
//   err_code   out  00 none, 01 zero amount, 10 insufficient stock, 11 timeout
//   c500_cnt   out  500 notes remaining in cassette
//   c100_cnt   out  100 notes remaining in cassette
// -----------------------------------------------------------------------------
module atm_cash_dispense_ctrl #(
    parameter int AMT_W       = 8,
    parameter int CNT_W       = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             load_cass,
    input  logic [CNT_W-1:0] load_c500,
    input  logic [CNT_W-1:0] load_c100,
    output logic             note_req,
    output logic             note_sel,
    input  logic             note_ack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] c500_cnt,
    output logic [CNT_W-1:0] c100_cnt
);

    localparam int CMP_W = AMT_W + CNT_W;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ZERO  = 2'b01;
    localparam logic [1:0] ERR_STOCK = 2'b10;
`ifdef DISPENSE_TIMEOUT_EN
    localparam logic [1:0] ERR_TMO   = 2'b11;
    localparam int         TMO_W     = $clog2(TIMEOUT_CYC + 1);
`endif

    localparam logic [AMT_W-1:0] NOTE_RATIO = AMT_W'(5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAN,
        S_CHECK,
        S_REQ,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_reg,    state_next;
    logic [AMT_W-1:0] rem_reg,      rem_next;
    logic [AMT_W-1:0] plan500_reg,  plan500_next;
    logic [AMT_W-1:0] plan100_reg,  plan100_next;
    logic [CNT_W-1:0] c500_reg,     c500_next;
    logic [CNT_W-1:0] c100_reg,     c100_next;
    logic [1:0]       err_code_reg, err_code_next;
`ifdef DISPENSE_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt_reg,  tmo_cnt_next;
`endif

    // Amount-width and count-width values are compared in a common width so
    // neither side is truncated whatever the parameter choice.
    logic [CMP_W-1:0] plan500_ext;
    logic [CMP_W-1:0] c500_ext;
    logic [CMP_W-1:0] rem_ext;
    logic [CMP_W-1:0] c100_ext;

    assign plan500_ext = {{CNT_W{1'b0}}, plan500_reg};
    assign rem_ext     = {{CNT_W{1'b0}}, rem_reg};
    assign c500_ext    = {{AMT_W{1'b0}}, c500_reg};
    assign c100_ext    = {{AMT_W{1'b0}}, c100_reg};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            rem_reg      <= '0;
            plan500_reg  <= '0;
            plan100_reg  <= '0;
            c500_reg     <= '0;
            c100_reg     <= '0;
            err_code_reg <= ERR_NONE;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            rem_reg      <= rem_next;
            plan500_reg  <= plan500_next;
            plan100_reg  <= plan100_next;
            c500_reg     <= c500_next;
            c100_reg     <= c100_next;
            err_code_reg <= err_code_next;
`ifdef DISPENSE_TIMEOUT_EN
            tmo_cnt_reg  <= tmo_cnt_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        rem_next      = rem_reg;
        plan500_next  = plan500_reg;
        plan100_next  = plan100_reg;
        c500_next     = c500_reg;
        c100_next     = c100_reg;
        err_code_next = err_code_reg;
`ifdef DISPENSE_TIMEOUT_EN
        tmo_cnt_next  = tmo_cnt_reg;
`endif

        case (state_reg)
            S_IDLE: begin
                if (load_cass) begin
                    c500_next = load_c500;
                    c100_next = load_c100;
                end else if (start) begin
                    rem_next      = amount;
                    plan500_next  = '0;
                    plan100_next  = '0;
                    err_code_next = ERR_NONE;
                    state_next    = S_PLAN;
                end
            end

            S_PLAN: begin
                // rem==0 with nothing planned can only be the first PLAN
                // cycle of a zero-amount request.
                if (rem_reg == '0 && plan500_reg == '0) begin
                    err_code_next = ERR_ZERO;
                    state_next    = S_FAULT;
                end else if (rem_reg >= NOTE_RATIO && plan500_ext < c500_ext) begin
                    plan500_next = plan500_reg + AMT_W'(1);
                    rem_next     = rem_reg - NOTE_RATIO;
                end else begin
                    state_next = S_CHECK;
                end
            end

            S_CHECK: begin
                if (rem_ext > c100_ext) begin
                    err_code_next = ERR_STOCK;
                    state_next    = S_FAULT;
                end else begin
                    plan100_next = rem_reg;
                    rem_next     = '0;
                    state_next   = S_REQ;
`ifdef DISPENSE_TIMEOUT_EN
                    tmo_cnt_next = '0;
`endif
                end
            end

            S_REQ: begin
                if (note_ack) begin
                    if (plan500_reg != '0) begin
                        plan500_next = plan500_reg - AMT_W'(1);
                        c500_next    = c500_reg - CNT_W'(1);
                    end else begin
                        plan100_next = plan100_reg - AMT_W'(1);
                        c100_next    = c100_reg - CNT_W'(1);
                    end
                    state_next = S_GAP;
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // This is the last allowed request cycle without ack.
                    err_code_next = ERR_TMO;
                    state_next    = S_FAULT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
                end
`endif
            end

            S_GAP: begin
                if (plan500_reg != '0 || plan100_reg != '0) begin
                    state_next = S_REQ;
`ifdef DISPENSE_TIMEOUT_EN
                    tmo_cnt_next = '0;
`endif
                end else begin
                    state_next = S_DONE;
                end
            end

            S_DONE:  state_next = S_IDLE;
            S_FAULT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake and status outputs decode straight from the state register so
    // an asynchronous reset removes note_req without waiting for a clock.
    assign note_req = (state_reg == S_REQ);
    assign note_sel = (state_reg == S_REQ) && (plan500_reg != '0);
    assign busy     = (state_reg != S_IDLE);
    assign done     = (state_reg == S_DONE);
    assign error    = (state_reg == S_FAULT);
    assign err_code = err_code_reg;
    assign c500_cnt = c500_reg;
    assign c100_cnt = c100_reg;

endmodule

// File: tb/tb_atm_cash_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_cash_dispense_ctrl
//
// Scoreboard bench. The stimulus side computes each request's outcome from the
// withdrawal rules (note mix by division, stock check, resulting counts) and
// queues the expected note sequence and final response. A monitor compares
// every accepted note and every done/error pulse against those queues. A
// separate responder plays the mechanism with random ack latency and stray
// acks outside requests.
// -----------------------------------------------------------------------------
module tb_atm_cash_dispense_ctrl;

    localparam int AMT_W = 8;
    localparam int CNT_W = 10;
    localparam int TMO   = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             load_cass;
    logic [CNT_W-1:0] load_c500;
    logic [CNT_W-1:0] load_c100;
    logic             note_req;
    logic             note_sel;
    logic             note_ack;
    logic             busy;
    logic             done;
    logic             error;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] c500_cnt;
    logic [CNT_W-1:0] c100_cnt;

    always #5 clock = ~clock;

    atm_cash_dispense_ctrl #(
        .AMT_W      (AMT_W),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .amount   (amount),
        .load_cass(load_cass),
        .load_c500(load_c500),
        .load_c100(load_c100),
        .note_req (note_req),
        .note_sel (note_sel),
        .note_ack (note_ack),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .c500_cnt (c500_cnt),
        .c100_cnt (c100_cnt)
    );

    typedef struct {
        bit   is_err;
        int   code;
        int   c5;
        int   c1;
        int   pending;   // planned notes that will never be acked (timeout)
    } resp_t;

    bit    note_q[$];
    resp_t resp_q[$];

    int checks = 0;
    int errors = 0;
    int m500   = 0;
    int m100   = 0;
    int ack_budget = -1;   // -1 unlimited, otherwise acks still allowed
    int txn_no = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Outcome of a withdrawal straight from the rules: as many 500s as the
    // amount and stock allow, the remainder in 100s if the stock covers it.
    task automatic model_start(input int amt);
        resp_t r;
        int    n5;
        int    rem;
        r.is_err  = 1'b0;
        r.code    = 0;
        r.pending = 0;
        if (amt == 0) begin
            r.is_err = 1'b1;
            r.code   = 1;
        end else begin
            n5 = amt / 5;
            if (n5 > m500) n5 = m500;
            rem = amt - 5 * n5;
            if (rem > m100) begin
                r.is_err = 1'b1;
                r.code   = 2;
            end else begin
                for (int i = 0; i < n5; i++)  note_q.push_back(1'b1);
                for (int i = 0; i < rem; i++) note_q.push_back(1'b0);
                m500 -= n5;
                m100 -= rem;
            end
        end
        r.c5 = m500;
        r.c1 = m100;
        resp_q.push_back(r);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input int c5, input int c1);
        cyc();
        load_cass = 1'b1;
        load_c500 = CNT_W'(c5);
        load_c100 = CNT_W'(c1);
        m500 = c5;
        m100 = c1;
        cyc();
        load_cass = 1'b0;
    endtask

    task automatic do_start(input int amt);
        cyc();
        start  = 1'b1;
        amount = AMT_W'(amt);
        model_start(amt);
        cyc();
        start = 1'b0;
    endtask

    // Wait for IDLE; optionally pulse start/load_cass while busy, which the
    // controller must ignore.
    task automatic wait_idle(input bit noise);
        int n = 0;
        while (busy && n < 5000) begin
            start     = 1'b0;
            load_cass = 1'b0;
            if (noise && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    start  = 1'b1;
                    amount = AMT_W'($urandom_range(1, 60));
                end else begin
                    load_cass = 1'b1;
                    load_c500 = CNT_W'($urandom_range(0, 1023));
                    load_c100 = CNT_W'($urandom_range(0, 1023));
                end
            end
            cyc();
            n++;
        end
        start     = 1'b0;
        load_cass = 1'b0;
        chk("idle_wait_busy", busy, 0);
    endtask

    // Mechanism model: acks a request after a random number of cycles, and
    // occasionally raises a stray ack when nothing is requested.
    initial begin
        note_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            note_ack = 1'b0;
            if (note_req) begin
                if (ack_budget != 0 && $urandom_range(0, 2) == 0) begin
                    note_ack = 1'b1;
                    if (ack_budget > 0) ack_budget--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                note_ack = 1'b1;
            end
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (reset_n) begin
            if (note_req && note_q.size() == 0)
                chk("unexpected_note_req", 1, 0);
            if (note_req && note_ack && note_q.size() != 0)
                chk("note_sel", note_sel, note_q.pop_front());
            if (done || error) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_response", 1, 0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    txn_no++;
                    $display("txn %0d %s err_code=%0d c500=%0d c100=%0d",
                             txn_no, error ? "error" : "done", err_code, c500_cnt, c100_cnt);
                    chk("resp_is_error", error, r.is_err);
                    chk("resp_done", done, !r.is_err);
                    chk("resp_err_code", err_code, r.code);
                    chk("resp_c500", c500_cnt, r.c5);
                    chk("resp_c100", c100_cnt, r.c1);
                    chk("resp_notes_left", note_q.size(), r.pending);
                    note_q.delete();
                end
            end
        end
    end

    initial begin
        int n;
        reset_n   = 1'b0;
        start     = 1'b0;
        amount    = '0;
        load_cass = 1'b0;
        load_c500 = '0;
        load_c100 = '0;
        repeat (3) cyc();

        chk("rst_note_req", note_req, 0);
        chk("rst_note_sel", note_sel, 0);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_error",    error,    0);
        chk("rst_err_code", err_code, 0);
        chk("rst_c500",     c500_cnt, 0);
        chk("rst_c100",     c100_cnt, 0);
        reset_n = 1'b1;
        cyc();

        // Note mix 500,500,100,100,100, with ignored pulses while busy
        do_load(10, 10);
        do_start(13);
        wait_idle(1);
        chk("mix_c500", c500_cnt, 8);
        chk("mix_c100", c100_cnt, 7);
        chk("mix_err_code", err_code, 0);

        // Zero amount: error after two busy cycles, no note
        do_start(0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            cyc();
        end
        chk("zero_busy_cycles", n, 2);
        chk("zero_err_code_held", err_code, 1);

        // Stock short: one 500 leaves 4 which exceeds two 100s
        do_load(1, 2);
        do_start(9);
        wait_idle(0);
        chk("short_err_code", err_code, 2);
        chk("short_c500", c500_cnt, 1);
        chk("short_c100", c100_cnt, 2);

        // Load and start together in IDLE: load wins
        cyc();
        load_cass = 1'b1;
        start     = 1'b1;
        amount    = AMT_W'(7);
        load_c500 = CNT_W'(3);
        load_c100 = CNT_W'(4);
        m500 = 3;
        m100 = 4;
        cyc();
        load_cass = 1'b0;
        start     = 1'b0;
        chk("same_cycle_busy", busy, 0);
        chk("same_cycle_c500", c500_cnt, 3);
        chk("same_cycle_c100", c100_cnt, 4);

`ifdef DISPENSE_TIMEOUT_EN
        // First note acked, second withheld until the controller gives up
        do_load(10, 10);
        ack_budget = 1;
        cyc();
        start  = 1'b1;
        amount = AMT_W'(10);
        note_q.push_back(1'b1);
        note_q.push_back(1'b1);
        resp_q.push_back('{is_err: 1'b1, code: 3, c5: 9, c1: 10, pending: 1});
        m500 = 9;
        m100 = 10;
        cyc();
        start = 1'b0;
        wait_idle(0);
        ack_budget = -1;
        chk("tmo_err_code", err_code, 3);
        chk("tmo_c500", c500_cnt, 9);
`endif

        // Asynchronous reset while a note is requested
        do_load(10, 10);
        ack_budget = 0;
        do_start(10);
        n = 0;
        while (!note_req && n < 100) begin
            n++;
            cyc();
        end
        chk("arst_req_before", note_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_note_req", note_req, 0);
        chk("arst_busy",     busy,     0);
        chk("arst_c500",     c500_cnt, 0);
        chk("arst_c100",     c100_cnt, 0);
        note_q.delete();
        resp_q.delete();
        m500 = 0;
        m100 = 0;
        ack_budget = -1;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
        chk("arst_idle_after", busy, 0);

        // Randomised transactions
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || $urandom_range(0, 2) == 0)
                do_load($urandom_range(0, 15), $urandom_range(0, 20));
            do_start($urandom_range(0, 60));
            wait_idle(1);
        end

        repeat (3) cyc();
        chk("end_resp_queue_empty", resp_q.size(), 0);
        chk("end_note_queue_empty", note_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
